// File: rtl/exec_pkg.sv
// exec_pkg: function codes, stage state encoding and decode helpers
// shared by the execute stage and its multiply/divide unit.
package exec_pkg;

    localparam logic [5:0] FUNC_SLL   = 6'h00;
    localparam logic [5:0] FUNC_SRL   = 6'h02;
    localparam logic [5:0] FUNC_SRA   = 6'h03;
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;
    localparam logic [5:0] FUNC_ADD   = 6'h20;
    localparam logic [5:0] FUNC_ADDU  = 6'h21;
    localparam logic [5:0] FUNC_SUB   = 6'h22;
    localparam logic [5:0] FUNC_SUBU  = 6'h23;
    localparam logic [5:0] FUNC_AND   = 6'h24;
    localparam logic [5:0] FUNC_OR    = 6'h25;
    localparam logic [5:0] FUNC_XOR   = 6'h26;
    localparam logic [5:0] FUNC_NOR   = 6'h27;
    localparam logic [5:0] FUNC_SLT   = 6'h2A;
    localparam logic [5:0] FUNC_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL
`ifdef EXEC_MULDIV_EN
        , ST_MD_RUN
`endif
    } state_e;

    function automatic logic is_muldiv(logic [5:0] f);
        return f inside {FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU};
    endfunction

endpackage

// File: rtl/exec_muldiv.sv
// exec_muldiv: W-cycle shift-add multiplier / restoring divider with HI/LO.
// Present only when EXEC_MULDIV_EN is defined.
`ifdef EXEC_MULDIV_EN
module exec_muldiv
    import exec_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [5:0]   func_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);
    localparam int CW = $clog2(W);

    logic [W-1:0]   rem_q, rem_d, q_q, q_d, md_q;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]  cnt_q;
    logic           busy_q, div_q, neg_q, sa_q, dz_q;
    logic           div, sgn, sa, sb;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     sum, shl, dif;
    logic [2*W-1:0] prod;

    // Iterate on magnitudes; signs are reapplied on the final edge.
    assign div   = func_i inside {FUNC_DIV, FUNC_DIVU};
    assign sgn   = (func_i == FUNC_MULT) || (func_i == FUNC_DIV);
    assign sa    = sgn & a_i[W-1];
    assign sb    = sgn & b_i[W-1];
    assign abs_a = sa ? -a_i : a_i;
    assign abs_b = sb ? -b_i : b_i;

    always_comb begin
        sum = {1'b0, rem_q} + (q_q[0] ? {1'b0, md_q} : '0);
        shl = {rem_q, q_q[W-1]};
        dif = shl - {1'b0, md_q};
        if (div_q) begin
            rem_d = dif[W] ? shl[W-1:0] : dif[W-1:0];
            q_d   = {q_q[W-2:0], ~dif[W]};
        end else begin
            rem_d = sum[W:1];
            q_d   = {sum[0], q_q[W-1:1]};
        end
        prod = {rem_d, q_d};
        if (neg_q) prod = -prod;
        if (div_q) begin
            lo_d = dz_q ? '1 : (neg_q ? -q_d : q_d);
            hi_d = sa_q ? -rem_d : rem_d;
        end else begin
            hi_d = prod[2*W-1:W];
            lo_d = prod[W-1:0];
        end
    end

    assign done_o = busy_q & (cnt_q == CW'(W - 1)) & ~abort_i;
    assign busy_o = busy_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            sa_q   <= 1'b0;
            dz_q   <= 1'b0;
            rem_q  <= '0;
            q_q    <= '0;
            md_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            div_q  <= div;
            neg_q  <= sa ^ sb;
            sa_q   <= sa;
            dz_q   <= (b_i == '0);
            rem_q  <= '0;
            q_q    <= div ? abs_a : abs_b;
            md_q   <= div ? abs_b : abs_a;
        end else if (busy_q) begin
            rem_q <= rem_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + CW'(1);
            if (done_o) begin
                busy_q <= 1'b0;
                hi_q   <= hi_d;
                lo_q   <= lo_d;
            end
        end
    end

endmodule
`endif

// File: rtl/execute_stage_mc.sv
// execute_stage_mc: single-entry execute stage, 1-cycle ALU plus optional
// iterative multiply/divide with HI/LO (enabled by EXEC_MULDIV_EN).
module execute_stage_mc
    import exec_pkg::*;
#(
    parameter int W      = 32,
    parameter int FUNC_W = 6,
    parameter int CTRL_W = 8,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FUNC_W-1:0] func_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [W-1:0]      pc_seq_in,
    input  logic [W-1:0]      a_in,
    input  logic [W-1:0]      b_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [W-1:0]      pc_seq_out,
    output logic [REG_W-1:0]  dest_out,
    output logic [W-1:0]      result_out,
    output logic              ovf_out,
    output logic              busy
);
    localparam int SH_W = $clog2(W);

    state_e            state_q, state_d, go_st;
    logic [FUNC_W-1:0] func_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [W-1:0]      pc_q, a_q, b_q;
    logic [REG_W-1:0]  dest_q;
    logic [5:0]        fn;
    logic [W-1:0]      sum, dif;
    logic [SH_W-1:0]   sh;
    logic              accept, ovf_raw;

    assign in_ready = !flush &&
        (state_q == ST_EMPTY || (state_q == ST_FULL && out_ready));
    assign accept = in_valid & in_ready;

`ifdef EXEC_MULDIV_EN
    logic [5:0]   fn_in;
    logic         md_in, done;
    logic [W-1:0] hi, lo;

    assign fn_in = 6'(func_in);
    assign md_in = is_muldiv(fn_in);
    assign go_st = md_in ? ST_MD_RUN : ST_FULL;

    exec_muldiv #(.W(W)) u_md (
        .clk     (clk),
        .reset   (reset),
        .start_i (accept & md_in),
        .abort_i (flush),
        .func_i  (fn_in),
        .a_i     (a_in),
        .b_i     (b_in),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );
`else
    assign go_st = ST_FULL;
    assign busy  = 1'b0;
`endif

    // Flush wins over both a new accept and a downstream handshake.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (accept) state_d = go_st;
                ST_FULL:  if (out_ready) state_d = accept ? go_st : ST_EMPTY;
`ifdef EXEC_MULDIV_EN
                ST_MD_RUN: if (done) state_d = ST_FULL;
`endif
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            func_q  <= '0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                func_q <= func_in;
                ctrl_q <= ctrl_in;
                pc_q   <= pc_seq_in;
                a_q    <= a_in;
                b_q    <= b_in;
                dest_q <= dest_in;
            end
        end
    end

    assign fn  = 6'(func_q);
    assign sum = a_q + b_q;
    assign dif = a_q - b_q;
    assign sh  = b_q[SH_W-1:0];

    always_comb begin
        result_out = '0;
        ovf_raw    = 1'b0;
        unique case (fn)
            FUNC_ADD: begin
                result_out = sum;
                ovf_raw = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
            end
            FUNC_SUB: begin
                result_out = dif;
                ovf_raw = (a_q[W-1] != b_q[W-1]) && (dif[W-1] != a_q[W-1]);
            end
            FUNC_ADDU: result_out = sum;
            FUNC_SUBU: result_out = dif;
            FUNC_AND:  result_out = a_q & b_q;
            FUNC_OR:   result_out = a_q | b_q;
            FUNC_XOR:  result_out = a_q ^ b_q;
            FUNC_NOR:  result_out = ~(a_q | b_q);
            FUNC_SLT:  result_out = {{(W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            FUNC_SLTU: result_out = {{(W-1){1'b0}}, a_q < b_q};
            FUNC_SLL:  result_out = a_q << sh;
            FUNC_SRL:  result_out = a_q >> sh;
            FUNC_SRA:  result_out = $signed(a_q) >>> sh;
`ifdef EXEC_MULDIV_EN
            FUNC_MULT, FUNC_MULTU,
            FUNC_DIV, FUNC_DIVU,
            FUNC_MFLO: result_out = lo;
            FUNC_MFHI: result_out = hi;
`endif
            default: ;
        endcase
    end

    assign out_valid  = (state_q == ST_FULL);
    assign ovf_out    = out_valid & ovf_raw;
    assign ctrl_out   = ctrl_q;
    assign pc_seq_out = pc_q;
    assign dest_out   = dest_q;

endmodule
